float_addsub_pipe: RTL and testbench
====================================

Name: float_addsub_pipe

Overview:
- Parametrised, pipelined floating-point adder/subtractor in the team's custom float format; successor to the fixed 16-bit float_add.
- Adds generic exponent/mantissa widths, an add/subtract mode, valid/ready flow control on both sides, and overflow/underflow/zero flags.
- Feeds the linear-equation solver datapath.
- Format: {sign, exp[EW-1:0], mant[MW-1:0]}.
  - sign 1 = positive, 0 = negative.
  - value = (mant / 2^(MW-1)) * 2^(exp - 2^(EW-1)).
  - Explicit leading one at mant[MW-1]; mant == 0 is zero.

Parameters:
EW, 5, exponent width; bias = 2^(EW-1)
MW, 10, mantissa width including explicit leading one
W, 1+EW+MW, derived word width (localparam, not overridable)

Ports:
clock  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
op  in  1  0 = a+b, 1 = a-b
adata  in  W  operand a
bdata  in  W  operand b
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
cdata  out  W  result
ovf  out  1  result exponent overflowed, saturated
unf  out  1  result underflowed, flushed to zero
zero  out  1  result is zero (includes unf)

Behaviour:
- Reset (asynchronous, rst_n low): all stage valid bits = 0; out_valid = 0, cdata = 0, ovf = unf = zero = 0. Reset mid-operation discards in-flight data; no output until new inputs arrive.
- Pipeline: 3 stages, latency 3 cycles from input handshake to out_valid with no stall; throughput 1/cycle.
  - S1 align
  - S2 add/sub
  - S3 normalise/pack
- Flow control:
  - adv = !out_valid || out_ready; in_ready = adv.
  - All stages shift together when adv; hold otherwise (no bubbles collapsed).
  - Input accepted when in_valid && in_ready.
  - cdata/flags are stable while out_valid && !out_ready.
- Operand rules:
  - op = 1 inverts b sign before S1.
  - Any operand with mant[MW-1] == 0 is treated as zero.
- S1 align:
  - Larger operand L = greater exponent; ties broken by greater mantissa, then a.
  - d = eL - eS; smaller mantissa shifted right by d, truncated, no guard bits.
  - d >= MW -> shifted mantissa = 0.
- S2 add/sub:
  - Equal signs: sum = mL + mS (MW+1 bits), sign = sL.
  - Otherwise: diff = mL - mS (never negative), sign = sL.
- S3 normalise:
  - Carry bit set: shift right 1 (truncate), exp + 1.
  - Otherwise: left-shift by leading-zero count lz of the MW-bit magnitude, exp - lz.
  - Exponent computed in EW+2 signed bits.
- Boundary cases:
  - Magnitude 0: cdata = {1'b1, 0, 0}, zero = 1, ovf = unf = 0.
  - exp > 2^EW - 1: ovf = 1, cdata = {sign, all-ones exp, all-ones mant}.
  - exp < 0: unf = 1, zero = 1, cdata = {1'b1, 0, 0}.
  - Both operands zero: zero result, sign positive.
- Flags are valid only with out_valid.

Decomposition:
- Package float_pkg:
  - EW/MW defaults and bias function
  - float_t-style packed struct builder (sign/exp/mant field extract functions)
  - canonical zero constant
  - saturate-max function
- Sub-module float_norm: parametrised leading-zero count plus left shifter used in S3; combinational, MW+1-bit input, outputs shifted mantissa and lz.

Test Plan:
- Add, op=0: a={1,16,766} (1.49609375), b={1,17,512} (2.0) -> after 3 cycles cdata={1,17,895} (3.49609375), flags 0.
- Sub, op=1, same operands -> cdata={0,15,516} (-0.50390625); normalisation shift of 2 exercised.
- Overflow: a=b={1,31,1023}, op=0 -> cdata={1,31,1023}, ovf=1.
- Underflow and cancellation:
  - a={1,0,513} - b={1,0,512} -> unf=1, zero=1, cdata={1,0,0}.
  - a-a -> zero=1, unf=0, cdata={1,0,0}.
- Stall: stream 6 random valid pairs, hold out_ready=0 for 4 cycles mid-stream -> in_ready drops, cdata held stable, all 6 results emerge in order and match a truncating reference model.
- Reset: assert rst_n low for 1 cycle with 2 ops in flight -> out_valid=0 immediately; no stale result after release; next op has latency 3.

Source files
------------

// File: rtl/float_pkg.sv
// Shared definitions for the custom float format {sign, exp, mant}: defaults,
// field helpers, and the canonical zero and saturation words.
package float_pkg;

    localparam int EW_DEF = 5;
    localparam int MW_DEF = 10;
    localparam int MAXW   = 64;

    typedef logic [MAXW-1:0] word_t;

    // Default-width view of the format; sign 1 = positive.
    typedef struct packed {
        logic              sign;
        logic [EW_DEF-1:0] exp;
        logic [MW_DEF-1:0] mant;
    } float_t;

    function automatic int bias(input int ew);
        return 1 << (ew - 1);
    endfunction

    function automatic word_t mask(input int n);
        return (word_t'(1) << n) - word_t'(1);
    endfunction

    function automatic logic get_sign(input word_t w, input int ew, input int mw);
        return w[ew+mw];
    endfunction

    function automatic int exp_field(input word_t w, input int ew, input int mw);
        return int'((w >> mw) & mask(ew));
    endfunction

    function automatic int mant_field(input word_t w, input int mw);
        return int'(w & mask(mw));
    endfunction

    function automatic word_t build(input logic sign, input int e, input int m,
                                    input int ew, input int mw);
        return (word_t'(sign) << (ew + mw)) | ((word_t'(e) & mask(ew)) << mw)
             | (word_t'(m) & mask(mw));
    endfunction

    // Zero is always reported with a positive sign.
    function automatic word_t canon_zero(input int ew, input int mw);
        return build(1'b1, 0, 0, ew, mw);
    endfunction

    function automatic word_t sat_max(input logic sign, input int ew, input int mw);
        return build(sign, -1, -1, ew, mw);
    endfunction

endpackage

// File: rtl/float_addsub_pipe_norm.sv
// Normaliser: right shift on carry-out, otherwise leading-zero count and
// left shift of the MW-bit magnitude.
module float_norm #(
    parameter int MW = 10,
    localparam int LZW = $clog2(MW + 1)
) (
    input  logic [MW:0]    mag,
    output logic [MW-1:0]  mant,
    output logic [LZW-1:0] lz
);

    logic found;

    always_comb begin
        lz    = LZW'(MW);
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found && mag[i]) begin
                lz    = LZW'(MW - 1 - i);
                found = 1'b1;
            end
        end
        if (mag[MW]) begin
            mant = mag[MW:1];
        end else begin
            mant = mag[MW-1:0] << lz;
        end
    end

endmodule

// File: rtl/float_addsub_pipe.sv
// Three-stage float adder/subtractor: S1 align, S2 add/sub, S3 normalise/pack.
// Truncating arithmetic throughout; flags travel with the result.
module float_addsub_pipe
    import float_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int MW = MW_DEF,
    localparam int W = 1 + EW + MW
) (
    input  logic         clock,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [W-1:0] adata,
    input  logic [W-1:0] bdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] cdata,
    output logic         ovf,
    output logic         unf,
    output logic         zero
);

    localparam int LZW = $clog2(MW + 1);
    localparam int XW  = EW + 2;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe advances as one when the output slot is empty or being
    // taken; otherwise every stage holds, so cdata/flags stay stable.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic          a_sign, b_sign, a_is_l;
    logic [EW-1:0] a_exp, b_exp, a_exp_raw, b_exp_raw, d;
    logic [MW-1:0] a_mant, b_mant, a_mant_raw, b_mant_raw;
    logic          l_sign, s_sign;
    logic [EW-1:0] l_exp, s_exp;
    logic [MW-1:0] l_mant, s_mant, s_shift;

    always_comb begin
        a_sign     = get_sign(word_t'(adata), EW, MW);
        b_sign     = get_sign(word_t'(bdata), EW, MW) ^ op;
        a_exp_raw  = EW'(exp_field(word_t'(adata), EW, MW));
        b_exp_raw  = EW'(exp_field(word_t'(bdata), EW, MW));
        a_mant_raw = MW'(mant_field(word_t'(adata), MW));
        b_mant_raw = MW'(mant_field(word_t'(bdata), MW));
        // An unnormalised operand is a zero; clearing its exponent keeps it
        // from winning the larger-operand selection.
        a_exp  = a_mant_raw[MW-1] ? a_exp_raw  : '0;
        a_mant = a_mant_raw[MW-1] ? a_mant_raw : '0;
        b_exp  = b_mant_raw[MW-1] ? b_exp_raw  : '0;
        b_mant = b_mant_raw[MW-1] ? b_mant_raw : '0;

        a_is_l = (a_exp > b_exp) || ((a_exp == b_exp) && (a_mant >= b_mant));
        l_sign = a_is_l ? a_sign : b_sign;
        l_exp  = a_is_l ? a_exp  : b_exp;
        l_mant = a_is_l ? a_mant : b_mant;
        s_sign = a_is_l ? b_sign : a_sign;
        s_exp  = a_is_l ? b_exp  : a_exp;
        s_mant = a_is_l ? b_mant : a_mant;

        d       = l_exp - s_exp;
        s_shift = (int'(d) >= MW) ? '0 : (s_mant >> d);
    end

    logic          s1_valid, s1_l_sign, s1_s_sign;
    logic [EW-1:0] s1_exp;
    logic [MW-1:0] s1_l_mant, s1_s_mant;

    logic          s2_valid, s2_sign;
    logic [EW-1:0] s2_exp;
    logic [MW:0]   s2_mag;
    logic [MW:0]   sum;

    always_comb begin
        if (s1_l_sign == s1_s_sign) begin
            sum = {1'b0, s1_l_mant} + {1'b0, s1_s_mant};
        end else begin
            sum = {1'b0, s1_l_mant} - {1'b0, s1_s_mant};
        end
    end

    logic [MW-1:0]  norm_mant;
    logic [LZW-1:0] norm_lz;
    logic [XW-1:0]  exp_base, exp_n;
    logic [W-1:0]   res_c;
    logic           res_ovf, res_unf, res_zero;

    float_norm #(.MW(MW)) u_norm (
        .mag  (s2_mag),
        .mant (norm_mant),
        .lz   (norm_lz)
    );

    // Exponent is carried in EW+2 bits: top bit flags underflow, next bit
    // (with top clear) flags overflow.
    always_comb begin
        exp_base = {2'b00, s2_exp};
        exp_n    = s2_mag[MW] ? exp_base + XW'(1) : exp_base - XW'(norm_lz);
        res_c    = {s2_sign, exp_n[EW-1:0], norm_mant};
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_zero = 1'b0;
        if (s2_mag == '0) begin
            res_c    = W'(canon_zero(EW, MW));
            res_zero = 1'b1;
        end else if (exp_n[XW-1]) begin
            res_c    = W'(canon_zero(EW, MW));
            res_unf  = 1'b1;
            res_zero = 1'b1;
        end else if (exp_n[XW-2]) begin
            res_c   = W'(sat_max(s2_sign, EW, MW));
            res_ovf = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_l_sign <= 1'b0;
            s1_s_sign <= 1'b0;
            s1_exp    <= '0;
            s1_l_mant <= '0;
            s1_s_mant <= '0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_mag    <= '0;
            out_valid <= 1'b0;
            cdata     <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_l_sign <= l_sign;
            s1_s_sign <= s_sign;
            s1_exp    <= l_exp;
            s1_l_mant <= l_mant;
            s1_s_mant <= s_shift;
            s2_valid  <= s1_valid;
            s2_sign   <= s1_l_sign;
            s2_exp    <= s1_exp;
            s2_mag    <= sum;
            out_valid <= s2_valid;
            cdata     <= res_c;
            ovf       <= res_ovf;
            unf       <= res_unf;
            zero      <= res_zero;
        end
    end

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Bench for float_addsub_pipe: directed cases, stall, reset and random traffic
// against an integer reference model of the truncating float arithmetic.
module tb_float_addsub_pipe;
    import float_pkg::*;

    localparam int EW = 5;
    localparam int MW = 10;
    localparam int W  = 1 + EW + MW;
    localparam int RW = W + 3;
    localparam logic [W-1:0] ZW = {1'b1, {(W-1){1'b0}}};

    logic         clock = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [W-1:0] adata = '0;
    logic [W-1:0] bdata = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] cdata;
    logic         ovf, unf, zero;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];

    float_addsub_pipe #(.EW(EW), .MW(MW)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .adata     (adata),
        .bdata     (bdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cdata     (cdata),
        .ovf       (ovf),
        .unf       (unf),
        .zero      (zero)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk(input int s, input int e, input int m);
        float_t f;
        f.sign = 1'(s);
        f.exp  = EW'(e);
        f.mant = MW'(m);
        return f;
    endfunction

    // Reference: align smaller onto larger exponent by truncating division,
    // add signed integers, then renormalise by plain scaling loops.
    function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        int sa, ea, ma, sb, eb, mb, sl, el, ml, ss, ms, d, r, mag, e;
        bit a_z, b_z;
        sa = int'(a[W-1]);       ea = int'(a[W-2:MW]); ma = int'(a[MW-1:0]);
        sb = int'(b[W-1] ^ sub); eb = int'(b[W-2:MW]); mb = int'(b[MW-1:0]);
        a_z = ma < (1 << (MW - 1));
        b_z = mb < (1 << (MW - 1));
        if (a_z && b_z) return {3'b001, ZW};
        if (a_z) begin
            sl = sb; el = eb; ml = mb; ss = sa; ms = 0;
        end else if (b_z) begin
            sl = sa; el = ea; ml = ma; ss = sb; ms = 0;
        end else begin
            if (ea > eb || (ea == eb && ma >= mb)) begin
                sl = sa; el = ea; ml = ma; ss = sb; ms = mb; d = ea - eb;
            end else begin
                sl = sb; el = eb; ml = mb; ss = sa; ms = ma; d = eb - ea;
            end
            ms = (d >= MW) ? 0 : (ms / (1 << d));
        end
        r   = (sl != 0 ? ml : -ml) + (ss != 0 ? ms : -ms);
        mag = (r < 0) ? -r : r;
        if (mag == 0) return {3'b001, ZW};
        e = el;
        while (mag >= (1 << MW)) begin mag = mag / 2; e = e + 1; end
        while (mag < (1 << (MW - 1))) begin mag = mag * 2; e = e - 1; end
        if (e > (1 << EW) - 1) return {3'b100, 1'(sl), {EW{1'b1}}, {MW{1'b1}}};
        if (e < 0) return {3'b011, ZW};
        return {3'b000, 1'(sl), EW'(e), MW'(mag)};
    endfunction

    function automatic logic [W-1:0] rand_word(input int near_exp);
        int s, e, m;
        s = int'($urandom_range(0, 1));
        if (near_exp >= 0 && $urandom_range(0, 2) != 0) begin
            e = near_exp + int'($urandom_range(0, 4)) - 2;
            e = (e < 0) ? 0 : ((e > 31) ? 31 : e);
        end else begin
            e = int'($urandom_range(0, 31));
        end
        m = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511))
                                        : int'($urandom_range(512, 1023));
        return mk(s, e, m);
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_empty: observed result %h expected none", cdata);
                end
                if (exp_q.size() != 0) check("scoreboard", {ovf, unf, zero, cdata}, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(model(adata, bdata, op));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
        int tries;
        logic took;
        adata = a; bdata = b; op = o; in_valid = 1'b1;
        tries = 0;
        took  = 1'b0;
        while (!took && tries < 50) begin
            @(negedge clock);
            took = in_ready;
            @(posedge clock); #1;
            tries++;
            if (!took) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        check("send_accept", RW'(took), RW'(1));
    endtask

    task automatic expect_result(input string tag, input logic [RW-1:0] expv);
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clock);
            n++;
            if (out_valid) got = 1'b1;
        end
        check({tag, "_latency"}, RW'(n), RW'(3));
        check(tag, {ovf, unf, zero, cdata}, expv);
        @(posedge clock); #1;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic o, input logic [RW-1:0] expv);
        out_ready = 1'b1;
        send(a, b, o);
        expect_result(tag, expv);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] ra[6];
    logic [W-1:0] rb[6];
    logic         ro[6];

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_outputs", {ovf, unf, zero, cdata}, '0);
        check("rst_out_valid", RW'(out_valid), '0);
        check("rst_in_ready", RW'(in_ready), RW'(1));
        rst_n = 1'b1;
        @(posedge clock); #1;

        directed("add", mk(1, 16, 766), mk(1, 17, 512), 1'b0, {3'b000, mk(1, 17, 895)});
        directed("sub", mk(1, 16, 766), mk(1, 17, 512), 1'b1, {3'b000, mk(0, 15, 516)});
        directed("ovf", mk(1, 31, 1023), mk(1, 31, 1023), 1'b0, {3'b100, mk(1, 31, 1023)});
        directed("unf", mk(1, 0, 513), mk(1, 0, 512), 1'b1, {3'b011, ZW});
        directed("cancel", mk(1, 16, 766), mk(1, 16, 766), 1'b1, {3'b001, ZW});
        directed("both_zero", mk(0, 7, 5), mk(0, 3, 0), 1'b0, {3'b001, ZW});
        directed("zero_operand", mk(1, 20, 0), mk(0, 4, 600), 1'b0, {3'b000, mk(0, 4, 600)});
        directed("far_shift", mk(1, 20, 512), mk(1, 5, 1023), 1'b0, {3'b000, mk(1, 20, 512)});

        // Stall mid-stream with the next operand pair waiting.
        for (int i = 0; i < 6; i++) begin
            ra[i] = rand_word(-1);
            rb[i] = rand_word(int'(ra[i][W-2:MW]));
            ro[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(ra[i], rb[i], ro[i]);
        out_ready = 1'b0;
        adata = ra[3]; bdata = rb[3]; op = ro[3]; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("stall_in_ready", RW'(in_ready), '0);
            check("stall_out_valid", RW'(out_valid), RW'(1));
            check("stall_hold", {ovf, unf, zero, cdata}, exp_q[0]);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        for (int i = 3; i < 6; i++) send(ra[i], rb[i], ro[i]);
        repeat (6) @(posedge clock);
        #1;
        check("stall_drain", RW'(exp_q.size()), '0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a;
            a = rand_word(-1);
            out_ready = ($urandom_range(0, 3) != 0);
            send(a, rand_word(int'(a[W-2:MW])), 1'($urandom_range(0, 1)));
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("random_drain", RW'(exp_q.size()), '0);

        // Reset with operations in flight.
        for (int i = 0; i < 3; i++) send(rand_word(-1), rand_word(-1), 1'b0);
        check("pre_reset_valid", RW'(out_valid), RW'(1));
        #1 rst_n = 1'b0;
        #1;
        check("reset_out_valid", RW'(out_valid), '0);
        check("reset_outputs", {ovf, unf, zero, cdata}, '0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("no_stale", RW'(out_valid), '0);
        end
        @(posedge clock); #1;
        directed("after_reset", mk(1, 16, 766), mk(1, 17, 512), 1'b0, {3'b000, mk(1, 17, 895)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
